// File: rtl/fir_decim_mac.sv
// Decimating FIR filter. It gathers DECIMATION samples, runs one serial TAPS-cycle MAC pass, then pushes one output.
// Build option FIR_SATURATE_EN: clamp each dequantized product and each accumulate step instead of wrapping.
module fir_decim_mac #(
    parameter int TAPS       = 32,
    parameter int DECIMATION = 8,
    parameter int DATA_SIZE  = 32,
    parameter int COEF_SIZE  = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [DATA_SIZE-1:0] x_in,
    input  logic                        x_empty,
    output logic                        x_rd_en,
    output logic signed [DATA_SIZE-1:0] y_out,
    input  logic                        y_out_full,
    output logic                        y_wr_en,
    input  logic                        coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_SIZE-1:0] coef_data,
    output logic                        coef_ready
);

    localparam int DW      = DATA_SIZE;
    localparam int PW      = DATA_SIZE + COEF_SIZE;
    localparam int AW      = $clog2(TAPS);
    localparam int CNT_MAX = (TAPS > DECIMATION) ? TAPS : DECIMATION;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {LOAD, MAC, WRITE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic signed [DW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]  y_out_q, y_out_d;
    logic                  y_wr_en_q, y_wr_en_d;

    logic signed [DW-1:0]        hist_q [TAPS];
    logic signed [COEF_SIZE-1:0] coef_q [TAPS];

    logic                  pop;
    logic                  coef_we;
    logic [AW-1:0]         tap;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  mag;
    logic signed [DW-1:0]  acc_nxt;

`ifdef FIR_SATURATE_EN
    localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] YMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] PMAX = PW'(YMAX);
    localparam logic signed [PW-1:0] PMIN = PW'(YMIN);

    logic signed [PW-1:0]  deq;
    logic signed [DW-1:0]  deq_s;
    logic [DW:0]           sum;
`endif

    assign pop        = (state_q == LOAD) && !x_empty;
    assign coef_we    = coef_wr_en && (state_q == LOAD) && (int'(coef_addr) < TAPS);
    assign x_rd_en    = pop;
    assign coef_ready = (state_q == LOAD);
    assign y_out      = y_out_q;
    assign y_wr_en    = y_wr_en_q;

    // One product per cycle. The product is dequantized by rounding toward zero:
    // shift the magnitude, then restore the sign.
    always_comb begin
        tap  = AW'(count_q);
        prod = PW'(hist_q[tap]) * PW'(coef_q[tap]);
        mag  = prod[PW-1] ? -prod : prod;
`ifdef FIR_SATURATE_EN
        deq = prod[PW-1] ? -(mag >>> FRAC_BITS) : (mag >>> FRAC_BITS);
        if (deq > PMAX)      deq_s = YMAX;
        else if (deq < PMIN) deq_s = YMIN;
        else                 deq_s = deq[DW-1:0];
        sum = {acc_q[DW-1], acc_q} + {deq_s[DW-1], deq_s};
        if (sum[DW] != sum[DW-1]) acc_nxt = sum[DW] ? YMIN : YMAX;
        else                      acc_nxt = sum[DW-1:0];
`else
        acc_nxt = acc_q + DW'(prod[PW-1] ? -(mag >>> FRAC_BITS) : (mag >>> FRAC_BITS));
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        y_wr_en_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (pop) begin
                    if (count_q == CNT_W'(DECIMATION - 1)) begin
                        count_d = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            MAC: begin
                acc_d = acc_nxt;
                if (count_q == CNT_W'(TAPS - 1)) begin
                    count_d = '0;
                    state_d = WRITE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            WRITE: begin
                // While the output FIFO is full, acc stays held and no pop happens.
                if (!y_out_full) begin
                    y_out_d   = acc_q;
                    y_wr_en_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            count_q   <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_wr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_wr_en_q <= y_wr_en_d;
        end
    end

    // History is a shift line with x[0] newest. It is cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                hist_q[k] <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            if (pop) begin
                for (int k = TAPS - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
                hist_q[0] <= x_in;
            end
            if (coef_we) coef_q[coef_addr] <= coef_data;
        end
    end

endmodule
